// File: rtl/fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | fifo_pkg : constants and types shared by the FIFO controller, RAM and      |
// |            read-stream adapter.                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int ADDR_WIDTH     = 4;
  localparam int ADDR_AVAILABLE = 13;

  typedef logic [1:0] buf_cnt_t;
  localparam logic [2:0] BUF_DEPTH = 3'd2;

  // A new read may be issued only if every word it could produce has a free slot.
  function automatic logic can_issue(input buf_cnt_t cnt, input logic pend, input logic pop);
    logic [2:0] occ;
    occ = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
    return (occ < BUF_DEPTH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_skid.sv
// +----------------------------------------------------------------------------+
// | fifo_rd_skid : 2-entry shift buffer; slot0 is the head, arrivals land in   |
// |                the first free slot after any same-cycle pop.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid,
  output buf_cnt_t              cnt
);

  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  buf_cnt_t              cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  buf_cnt_t              w_tail;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    w_tail  = cnt_q - {1'b0, rd};
    if (rd) begin
      slot0_d = slot1_q;
    end
    // Tail is computed after the pop so an arrival fills the slot just freed.
    if (wr) begin
      if (w_tail == 2'd0) begin
        slot0_d = wr_data;
      end else begin
        slot1_d = wr_data;
      end
    end
    cnt_d   = cnt_q + {1'b0, wr} - {1'b0, rd};
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign head  = slot0_q;
  assign valid = valid_q;
  assign cnt   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// +----------------------------------------------------------------------------+
// | fifo_rd_stream : FIFO read port (empty/r_en/r_data) to valid/ready stream. |
// | Optional accepted-word counter enabled by FIFO_RD_STREAM_STATS_EN.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  xfer_count
`endif
);

  logic     pend_q, pend_d;
  logic     w_pop;
  logic     w_r_en;
  buf_cnt_t w_buf_cnt;

  assign w_pop = m_valid & m_ready;

  // m_ready reaches r_en combinationally so a pop frees a slot in the same cycle.
  always_comb begin
    w_r_en = ~reset & ~empty & can_issue(w_buf_cnt, pend_q, w_pop);
    pend_d = w_r_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign r_en = w_r_en;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .wr      (pend_q),
    .wr_data (r_data),
    .rd      (w_pop),
    .head    (m_data),
    .valid   (m_valid),
    .cnt     (w_buf_cnt)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q + {{(CNT_WIDTH-1){1'b0}}, w_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

`default_nettype wire
